branch_predictor: RTL and testbench

- Fetch-side counterpart of the execute-stage branch resolver. Predicts branch direction and target for the fetch PC.
- Learns from resolved outcomes (taken flag and target) that execute sends back on an update port.
- Direct-mapped table: per-entry 2-bit saturating counter, tag, target and valid bit.
- Lookup result is registered, so the prediction is ready one cycle after the lookup request.

---
 rtl/branch_predictor_pkg.sv | 31 +++
 rtl/sat_counter_next.sv | 23 ++
 rtl/branch_predictor.sv | 128 ++++++++++++
 tb/tb_branch_predictor.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor.
// Holds the 2-bit counter encodings, the counter reset value, the PC increment,
// and helpers for tag width and PC index/tag extraction.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    CtrSnt = 2'b00,
    CtrWnt = 2'b01,
    CtrWt  = 2'b10,
    CtrSt  = 2'b11
  } ctr_e;

  localparam ctr_e        CtrReset = CtrWnt;
  localparam logic [31:0] PcIncr   = 32'd4;

  // The low two PC bits and the index bits are excluded from the tag.
  function automatic int unsigned tag_width(input int unsigned idx_bits);
    return 32 - idx_bits - 2;
  endfunction

  // Index = pc[idx_bits+1:2], returned right-aligned in 32 bits.
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned idx_bits);
    return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
  endfunction

  // Tag = pc[31:idx_bits+2], returned right-aligned in 32 bits.
  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned idx_bits);
    return pc >> (idx_bits + 2);
  endfunction

endpackage

// File: rtl/sat_counter_next.sv
// Combinational next-state for a 2-bit saturating branch counter.
// Ports:
//   cnt      - current counter value
//   taken    - resolved branch direction
//   cnt_next - counter value after training with taken
module sat_counter_next
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken && (cnt != CtrSt)) begin
      cnt_next = cnt + 2'd1;
    end else if (!taken && (cnt != CtrSnt)) begin
      cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch direction/target predictor for the fetch stage.
// Each entry holds a 2-bit saturating counter, tag, target and valid bit.
// The prediction is registered: it appears the cycle after lookup_valid.
// Optional macro BRANCH_PREDICTOR_GSHARE_EN XORs a global history register into
// the index (tag is still taken from the PC).
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   lookup_valid, lookup_pc  - fetch-side lookup request
//   pred_valid, pred_taken,
//   pred_target              - registered prediction
//   update_valid, update_pc,
//   update_taken,
//   update_target            - resolved branch outcome from execute
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned GHR_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target
);

  localparam int unsigned Entries = 1 << IDX_BITS;
  localparam int unsigned TagW    = tag_width(IDX_BITS);

  logic [1:0]      cnt_q [Entries];
  logic [TagW-1:0] tag_q [Entries];
  logic [31:0]     tgt_q [Entries];
  logic [Entries-1:0] vld_q;

  logic [IDX_BITS-1:0] lk_idx, up_idx;
  logic [TagW-1:0]     lk_tag, up_tag;
  logic                lk_hit, lk_taken, up_hit;
  logic [31:0]         lk_target;
  logic [1:0]          ctr_trained, cnt_d;

  assign lk_tag = TagW'(pc_tag(lookup_pc, IDX_BITS));
  assign up_tag = TagW'(pc_tag(update_pc, IDX_BITS));

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q;

  // Both ports use the history present this cycle; the update's own shift lands after.
  assign lk_idx = IDX_BITS'(pc_index(lookup_pc, IDX_BITS)) ^ IDX_BITS'(ghr_q);
  assign up_idx = IDX_BITS'(pc_index(update_pc, IDX_BITS)) ^ IDX_BITS'(ghr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (update_valid) begin
      ghr_q <= {ghr_q[GHR_BITS-2:0], update_taken};
    end
  end
`else
  assign lk_idx = IDX_BITS'(pc_index(lookup_pc, IDX_BITS));
  assign up_idx = IDX_BITS'(pc_index(update_pc, IDX_BITS));
`endif

  // Lookup reads the table before this edge's update write (no forwarding).
  always_comb begin
    lk_hit    = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken  = lk_hit && cnt_q[lk_idx][1];
    lk_target = lk_taken ? tgt_q[lk_idx] : lookup_pc + PcIncr;
  end

  sat_counter_next u_sat_counter_next (
    .cnt      (cnt_q[up_idx]),
    .taken    (update_taken),
    .cnt_next (ctr_trained)
  );

  // A miss reallocates the entry with a weak counter in the outcome's direction.
  always_comb begin
    up_hit = vld_q[up_idx] && (tag_q[up_idx] == up_tag);
    if (up_hit) begin
      cnt_d = ctr_trained;
    end else begin
      cnt_d = update_taken ? CtrWt : CtrWnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) begin
        cnt_q[i] <= CtrReset;
      end
      vld_q <= '0;
    end else if (update_valid) begin
      cnt_q[up_idx] <= cnt_d;
      vld_q[up_idx] <= 1'b1;
    end
  end

  // Tag/target need no reset: they are only used behind a set valid bit.
  always_ff @(posedge clk) begin
    if (!rst && update_valid) begin
      tag_q[up_idx] <= up_tag;
      if (update_taken) begin
        tgt_q[up_idx] <= update_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else if (lookup_valid) begin
      pred_valid  <= 1'b1;
      pred_taken  <= lk_taken;
      pred_target <= lk_target;
    end else begin
      pred_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int unsigned IdxBits = 6;
  localparam int unsigned Ent     = 1 << IdxBits;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;

  always #5 clk = ~clk;

  branch_predictor #(
    .IDX_BITS (IdxBits),
    .GHR_BITS (6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .lookup_valid  (lookup_valid),
    .lookup_pc     (lookup_pc),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .update_target (update_target)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: table of integer counters 0..3, tags, targets, valid flags.
  int          m_cnt [Ent];
  bit          m_vld [Ent];
  int unsigned m_tag [Ent];
  logic [31:0] m_tgt [Ent];
  int unsigned m_ghr;
  bit          e_valid, e_taken;
  logic [31:0] e_target;

  function automatic int unsigned m_idx(input logic [31:0] pc);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    return ((pc >> 2) ^ m_ghr) % Ent;
`else
    return (pc >> 2) % Ent;
`endif
  endfunction

  always @(posedge clk) begin : model
    int unsigned i;
    bit hit;
    if (rst) begin
      for (int k = 0; k < Ent; k++) begin
        m_cnt[k] = 1;
        m_vld[k] = 0;
      end
      m_ghr = 0; e_valid = 0; e_taken = 0; e_target = 0;
    end else begin
      if (lookup_valid) begin
        i = m_idx(lookup_pc);
        hit = m_vld[i] && (m_tag[i] == (lookup_pc >> (IdxBits + 2)));
        e_taken  = hit && (m_cnt[i] >= 2);
        e_target = e_taken ? m_tgt[i] : lookup_pc + 32'd4;
        e_valid  = 1;
      end else begin
        e_valid = 0;
      end
      if (update_valid) begin
        i = m_idx(update_pc);
        hit = m_vld[i] && (m_tag[i] == (update_pc >> (IdxBits + 2)));
        if (hit) m_cnt[i] = update_taken ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3)
                                         : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
        else     m_cnt[i] = update_taken ? 2 : 1;
        m_vld[i] = 1;
        m_tag[i] = update_pc >> (IdxBits + 2);
        if (update_taken) m_tgt[i] = update_target;
        m_ghr = ((m_ghr << 1) | 32'(update_taken)) % 64;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model pred_valid", 32'(pred_valid), 32'(e_valid));
      chk("model pred_taken", 32'(pred_taken), 32'(e_taken));
      chk("model pred_target", pred_target, e_target);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    lookup_valid = 1'b1; lookup_pc = pc;
    cyc();
    lookup_valid = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    update_valid = 1'b1; update_pc = pc; update_taken = t; update_target = tgt;
    cyc();
    update_valid = 1'b0;
  endtask

  task automatic expect_pred(input string name, input logic t, input logic [31:0] tgt);
    chk({name, " valid"}, 32'(pred_valid), 32'd1);
    chk({name, " taken"}, 32'(pred_taken), 32'(t));
    chk({name, " target"}, pred_target, tgt);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [23:0] tag;
    case ($urandom_range(0, 3))
      0:       tag = 24'h000000;
      1:       tag = 24'h000001;
      2:       tag = 24'h000002;
      default: tag = 24'hffffff;
    endcase
    return {tag, 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
  endfunction

  initial begin
    rst = 1'b1; lookup_valid = 1'b0; lookup_pc = '0;
    update_valid = 1'b0; update_pc = '0; update_taken = 1'b0; update_target = '0;
    cyc(); cyc();
    rst = 1'b0;
    chk("reset pred_valid", 32'(pred_valid), 32'd0);
    chk("reset pred_taken", 32'(pred_taken), 32'd0);
    chk("reset pred_target", pred_target, 32'd0);
    chk_en = 1'b1;

    lookup(32'hffff_fffc);
    expect_pred("wrap", 1'b0, 32'h0000_0000);

`ifndef BRANCH_PREDICTOR_GSHARE_EN
    lookup(32'h100);
    expect_pred("cold", 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h80);
    lookup(32'h100);
    expect_pred("trained", 1'b1, 32'h80);
    upd(32'h100, 1'b1, 32'h80);
    upd(32'h100, 1'b1, 32'h80);
    upd(32'h100, 1'b0, 32'h0);
    lookup(32'h100);
    expect_pred("sat high", 1'b1, 32'h80);
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b1, 32'h80);
    lookup(32'h100);
    expect_pred("sat low", 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h80);
    lookup(32'h200);
    expect_pred("alias miss", 1'b0, 32'h204);
    upd(32'h200, 1'b1, 32'h40);
    lookup(32'h100);
    expect_pred("realloc", 1'b0, 32'h104);
    lookup(32'h200);
    expect_pred("realloc new", 1'b1, 32'h40);
    upd(32'h104, 1'b0, 32'h0);
    lookup_valid = 1'b1; lookup_pc = 32'h104;
    update_valid = 1'b1; update_pc = 32'h104; update_taken = 1'b1; update_target = 32'h300;
    cyc();
    lookup_valid = 1'b0; update_valid = 1'b0;
    expect_pred("hazard old", 1'b0, 32'h108);
    lookup(32'h104);
    expect_pred("hazard new", 1'b1, 32'h300);
    rst = 1'b1; lookup_valid = 1'b1; lookup_pc = 32'h200;
    cyc();
    rst = 1'b0; lookup_valid = 1'b0;
    chk("midreset pred_valid", 32'(pred_valid), 32'd0);
    chk("midreset pred_target", pred_target, 32'd0);
    lookup(32'h200);
    expect_pred("cleared", 1'b0, 32'h204);
`else
    // Train 0x100 taken at history 0; lookups then run at history 1.
    upd(32'h100, 1'b1, 32'h80);
    lookup(32'h104);
    expect_pred("gshare xor hit", 1'b1, 32'h80);
    lookup(32'h100);
    expect_pred("gshare other hist", 1'b0, 32'h104);
`endif

    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 199) == 0);
      lookup_valid  = 1'($urandom_range(0, 1));
      lookup_pc     = rand_pc();
      update_valid  = 1'($urandom_range(0, 1));
      update_pc     = rand_pc();
      update_taken  = 1'($urandom_range(0, 1));
      update_target = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      cyc();
    end
    rst = 1'b0; lookup_valid = 1'b0; update_valid = 1'b0;
    cyc(); cyc();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
